// File: rtl/prog_mem_loader_pkg.sv
// Shared state encodings and constants for the program memory boot loader.
package prog_mem_loader_pkg;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      RUN   = 3'd3,
      ERROR = 3'd4
   } state_e;

   localparam logic [7:0] NOP_OPCODE = 8'hEA;
endpackage

// File: rtl/prog_mem_loader_prog_ram.sv
// Simple dual-port program RAM: synchronous write, registered read, storage not reset.
module prog_ram #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);
   logic [7:0] mem [0:(1<<ADDR_W)-1];
   logic [7:0] rdata_d, rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Same-address read during a write returns the pre-write contents.
   always_comb rdata_d = mem[raddr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/prog_mem_loader.sv
// Boot loader + program RAM in front of cpu_core; holds the CPU in reset while loading.
// Optional trailing checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module prog_mem_loader #(
   parameter int          ADDR_W    = 10,
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_valid,
   input  logic [7:0]      load_data,
   input  logic            load_last,
   output logic            load_ready,
   input  logic            start,
   input  logic            reload,
   input  logic [15:0]     cpu_addr,
   output logic [7:0]      cpu_din,
   output logic            cpu_reset,
   output logic [ADDR_W:0] loaded_count,
   output logic            busy,
   output logic            error,
   output logic [2:0]      state_out
);
   import prog_mem_loader_pkg::*;

   // state | meaning
   // IDLE  | CPU in reset, waiting for first byte or start
   // LOAD  | receiving program bytes into RAM
   // CHECK | waiting for checksum byte (checksum build only)
   // RUN   | CPU released, stream ignored
   // ERROR | overflow or bad checksum, CPU in reset until reload

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
`ifdef LOADER_CHECKSUM_EN
   localparam state_e          FINAL_ST = CHECK;
`else
   localparam state_e          FINAL_ST = RUN;
`endif

   state_e            state_d, state_q;
   logic [ADDR_W-1:0] wptr_d, wptr_q;
   logic [ADDR_W:0]   cnt_d, cnt_q;
   logic              cpu_reset_d, cpu_reset_q;
   logic              nop_sel_d, nop_sel_q;
   logic              accept, wr_en, clr;
   logic [7:0]        ram_rdata;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        checksum_d, checksum_q;
`endif

   assign load_ready = (state_q == IDLE) || (state_q == LOAD) || (state_q == CHECK);
   assign accept     = load_valid && load_ready;

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      clr     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               wr_en   = 1'b1;
               state_d = load_last ? FINAL_ST : LOAD;
            end else if (start) begin
               state_d = RUN;
            end
         end
         LOAD: begin
            if (accept) begin
               if (cnt_q == FULL_CNT) begin
                  state_d = ERROR;
               end else begin
                  wr_en = 1'b1;
                  if (load_last) state_d = FINAL_ST;
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            if (reload) begin
               state_d = IDLE;
               clr     = 1'b1;
            end else if (accept) begin
               state_d = (load_data == checksum_q) ? RUN : ERROR;
            end
         end
`endif
         RUN, ERROR: begin
            if (reload) begin
               state_d = IDLE;
               clr     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (wr_en) begin
         wptr_d = wptr_q + 1'b1;
         cnt_d  = cnt_q + 1'b1;
      end
      if (clr) begin
         wptr_d = '0;
         cnt_d  = '0;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_comb begin
      checksum_d = checksum_q;
      if (wr_en) checksum_d = checksum_q + load_data;
      if (clr)   checksum_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) checksum_q <= '0;
      else       checksum_q <= checksum_d;
   end
`endif

   // cpu_reset tracks the next state so it drops on the final accept edge.
   assign cpu_reset_d = (state_d != RUN);
   assign nop_sel_d   = (cpu_addr[15:ADDR_W] != BASE_ADDR[15:ADDR_W]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wptr_q      <= '0;
         cnt_q       <= '0;
         cpu_reset_q <= 1'b1;
         nop_sel_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         cnt_q       <= cnt_d;
         cpu_reset_q <= cpu_reset_d;
         nop_sel_q   <= nop_sel_d;
      end
   end

   prog_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .rst   (reset),
      .we    (wr_en),
      .waddr (wptr_q),
      .wdata (load_data),
      .raddr (cpu_addr[ADDR_W-1:0]),
      .rdata (ram_rdata)
   );

   assign cpu_din      = nop_sel_q ? NOP_OPCODE : ram_rdata;
   assign cpu_reset    = cpu_reset_q;
   assign loaded_count = cnt_q;
   assign busy         = (state_q == LOAD) || (state_q == CHECK);
   assign error        = (state_q == ERROR);
   assign state_out    = state_q;
endmodule
